cu: RTL and testbench

- Instruction decoder for the 5-stage MIPS pipeline (P6 instruction subset).
- Takes one 32-bit instruction and produces the control signals a pipeline stage needs: memory-write enable, access width/sign, register-write enable, destination select, write-back source select, and the result-ready latency T.
- One instance per stage. The Memory stage uses it to form byteen, mem_write, load extraction and regw_adr/reg_write.
- Decode is purely combinational; clk/reset are present for interface uniformity.

---
 rtl/cu.sv | 165 ++++++++++++++++
 tb/tb_cu.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cu.sv
// ---------------------------------------------------------------------------
// cu : instruction decoder for the 5-stage MIPS pipeline (P6 subset).
//
// One instance per pipeline stage. Decodes a 32-bit instruction word into the
// control signals that stage needs. Decode is purely combinational; clk and
// reset exist only so every stage instance has the same interface.
//
// Ports
//   clk          in   1   system clock (decode does not depend on it)
//   reset        in   1   synchronous active-high reset (no effect on decode)
//   instr        in  32   instruction word
//   memw_enable  out  1   1 for stores
//   regw_enable  out  1   1 when the instruction writes the GPR file
//   regw_src     out  4   0 ALU, 1 mem data, 2 imm32 (lui), 3 PC+8, 4 HI/LO
//   regw_dst     out  4   0 rt, 1 rd, 2 $31
//   width        out  3   0 none, 1 word, 2 halfword, 3 byte
//   sign_ext     out  1   1 for loads (read data sign-extended)
//   T            out  5   Tnew measured from entry to Execute
// ---------------------------------------------------------------------------
module cu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        memw_enable,
  output logic        regw_enable,
  output logic [3:0]  regw_src,
  output logic [3:0]  regw_dst,
  output logic [2:0]  width,
  output logic        sign_ext,
  output logic [4:0]  T
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type functs that produce a GPR write
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  // Field encodings
  localparam logic [3:0] SRC_ALU  = 4'd0;
  localparam logic [3:0] SRC_MEM  = 4'd1;
  localparam logic [3:0] SRC_IMM  = 4'd2;
  localparam logic [3:0] SRC_PC8  = 4'd3;
  localparam logic [3:0] SRC_MDU  = 4'd4;
  localparam logic [3:0] DST_RT   = 4'd0;
  localparam logic [3:0] DST_RD   = 4'd1;
  localparam logic [3:0] DST_RA   = 4'd2;
  localparam logic [2:0] W_NONE   = 3'd0;
  localparam logic [2:0] W_WORD   = 3'd1;
  localparam logic [2:0] W_HALF   = 3'd2;
  localparam logic [2:0] W_BYTE   = 3'd3;

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  // Register-number fields and shamt are not part of decode; collected here
  // together with clk/reset so they are visibly consumed.
  logic       w_unused;

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[5:0];
  assign w_unused = &{1'b0, clk, reset, instr[25:6]};

  // Main decode: every output defaults to 0 and only listed encodings set bits.
  always_comb begin
    memw_enable = 1'b0;
    regw_enable = 1'b0;
    regw_src    = SRC_ALU;
    regw_dst    = DST_RT;
    width       = W_NONE;
    sign_ext    = 1'b0;
    T           = 5'd0;
    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU: begin
            regw_enable = 1'b1;
            regw_dst    = DST_RD;
            regw_src    = SRC_ALU;
            T           = 5'd1;
          end
          FN_MFHI, FN_MFLO: begin
            regw_enable = 1'b1;
            regw_dst    = DST_RD;
            regw_src    = SRC_MDU;
            T           = 5'd1;
          end
          // mult/div/mthi/mtlo/jr/sll and unknown functs: no effects
          default: begin
            regw_enable = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        regw_enable = 1'b1;
        regw_dst    = DST_RT;
        regw_src    = SRC_ALU;
        T           = 5'd1;
      end
      OP_LUI: begin
        regw_enable = 1'b1;
        regw_dst    = DST_RT;
        regw_src    = SRC_IMM;
        T           = 5'd0;
      end
      OP_LW, OP_LH, OP_LB: begin
        regw_enable = 1'b1;
        regw_dst    = DST_RT;
        regw_src    = SRC_MEM;
        sign_ext    = 1'b1;
        T           = 5'd2;
        if (w_opcode == OP_LW) begin
          width = W_WORD;
        end else if (w_opcode == OP_LH) begin
          width = W_HALF;
        end else begin
          width = W_BYTE;
        end
      end
      OP_SW, OP_SH, OP_SB: begin
        memw_enable = 1'b1;
        if (w_opcode == OP_SW) begin
          width = W_WORD;
        end else if (w_opcode == OP_SH) begin
          width = W_HALF;
        end else begin
          width = W_BYTE;
        end
      end
      OP_JAL: begin
        regw_enable = 1'b1;
        regw_dst    = DST_RA;
        regw_src    = SRC_PC8;
        T           = 5'd0;
      end
      // Branches write nothing; unknown opcodes decode as nop
      OP_BEQ, OP_BNE: begin
        regw_enable = 1'b0;
      end
      default: begin
        regw_enable = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cu.sv
module tb_cu;

  typedef struct packed {
    logic       memw;
    logic       regw;
    logic [3:0] src;
    logic [3:0] dst;
    logic [2:0] wid;
    logic       sx;
    logic [4:0] t;
  } out_t;

  typedef struct {
    string       name;
    logic [31:0] ins;
    out_t        exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        memw_enable;
  logic        regw_enable;
  logic [3:0]  regw_src;
  logic [3:0]  regw_dst;
  logic [2:0]  width;
  logic        sign_ext;
  logic [4:0]  T;

  int total;
  int bad;

  cu dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .memw_enable (memw_enable),
    .regw_enable (regw_enable),
    .regw_src    (regw_src),
    .regw_dst    (regw_dst),
    .width       (width),
    .sign_ext    (sign_ext),
    .T           (T)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(input logic m, input logic r, input int src,
                              input int dst, input int w, input logic s, input int t);
    out_t o;
    o.memw = m;
    o.regw = r;
    o.src  = src[3:0];
    o.dst  = dst[3:0];
    o.wid  = w[2:0];
    o.sx   = s;
    o.t    = t[4:0];
    return o;
  endfunction

  function automatic out_t got();
    return {memw_enable, regw_enable, regw_src, regw_dst, width, sign_ext, T};
  endfunction

  // Reference model: instruction classes expressed as lookup lists.
  function automatic out_t model(input logic [31:0] ins);
    int op;
    int fn;
    int idx;
    int alu_r[6]  = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2a, 32'h2b};
    int mdu_r[2]  = '{32'h10, 32'h12};
    int alu_i[3]  = '{32'h08, 32'h0c, 32'h0d};
    int loads[3]  = '{32'h23, 32'h21, 32'h20};   // width = position+1
    int stores[3] = '{32'h2b, 32'h29, 32'h28};
    out_t o;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    o  = '0;
    if (op == 0) begin
      foreach (alu_r[i]) if (alu_r[i] == fn) o = mk(0, 1, 0, 1, 0, 0, 1);
      foreach (mdu_r[i]) if (mdu_r[i] == fn) o = mk(0, 1, 4, 1, 0, 0, 1);
    end else begin
      foreach (alu_i[i]) if (alu_i[i] == op) o = mk(0, 1, 0, 0, 0, 0, 1);
      if (op == 32'h0f) o = mk(0, 1, 2, 0, 0, 0, 0);
      if (op == 32'h03) o = mk(0, 1, 3, 2, 0, 0, 0);
      idx = -1;
      foreach (loads[i]) if (loads[i] == op) idx = i;
      if (idx >= 0) o = mk(0, 1, 1, 0, idx + 1, 1, 2);
      idx = -1;
      foreach (stores[i]) if (stores[i] == op) idx = i;
      if (idx >= 0) o = mk(1, 0, 0, 0, idx + 1, 0, 0);
    end
    return o;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL %s: invariant violated, outputs %h instr %h", name, got(), instr);
    end
  endtask

  task automatic apply(input logic [31:0] ins);
    @(negedge clk);
    instr = ins;
    #1;
  endtask

  vec_t vecs[16];
  int   ops[22] = '{32'h00, 32'h00, 32'h00, 32'h03, 32'h04, 32'h05, 32'h08,
                    32'h0c, 32'h0d, 32'h0f, 32'h20, 32'h21, 32'h23, 32'h28,
                    32'h29, 32'h2b, 32'h02, 32'h0a, 32'h24, 32'h3f, 32'h2a, 32'h22};

  initial begin
    out_t        o;
    logic [31:0] r;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    instr = 32'h0000_0000;

    vecs[0]  = '{"add",     32'h0022_1820, mk(0, 1, 0, 1, 0, 0, 1)};
    vecs[1]  = '{"lw",      32'h8FA8_0004, mk(0, 1, 1, 0, 1, 1, 2)};
    vecs[2]  = '{"lh",      32'h87A8_0004, mk(0, 1, 1, 0, 2, 1, 2)};
    vecs[3]  = '{"lb",      32'h83A8_0004, mk(0, 1, 1, 0, 3, 1, 2)};
    vecs[4]  = '{"sh",      32'hA509_0002, mk(1, 0, 0, 0, 2, 0, 0)};
    vecs[5]  = '{"sw",      32'hAD09_0002, mk(1, 0, 0, 0, 1, 0, 0)};
    vecs[6]  = '{"sb",      32'hA109_0002, mk(1, 0, 0, 0, 3, 0, 0)};
    vecs[7]  = '{"jal",     32'h0C00_0010, mk(0, 1, 3, 2, 0, 0, 0)};
    vecs[8]  = '{"lui",     32'h3C01_1234, mk(0, 1, 2, 0, 0, 0, 0)};
    vecs[9]  = '{"mflo",    32'h0000_2012, mk(0, 1, 4, 1, 0, 0, 1)};
    vecs[10] = '{"mult",    32'h0022_0018, mk(0, 0, 0, 0, 0, 0, 0)};
    vecs[11] = '{"nop",     32'h0000_0000, mk(0, 0, 0, 0, 0, 0, 0)};
    vecs[12] = '{"beq",     32'h1022_0003, mk(0, 0, 0, 0, 0, 0, 0)};
    vecs[13] = '{"jr",      32'h03E0_0008, mk(0, 0, 0, 0, 0, 0, 0)};
    vecs[14] = '{"illegal", 32'hFC00_0000, mk(0, 0, 0, 0, 0, 0, 0)};
    vecs[15] = '{"ori_r0",  32'h3400_FFFF, mk(0, 1, 0, 0, 0, 0, 1)};

    // Decode must not depend on reset: check the first vector while in reset
    apply(vecs[1].ins);
    check("lw_in_reset", got(), vecs[1].exp);
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].ins);
      check(vecs[i].name, got(), vecs[i].exp);
    end

    // Reset asserted and released across clock edges while holding lw
    apply(32'h8FA8_0004);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("lw_reset_hi", got(), vecs[1].exp);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("lw_reset_lo", got(), vecs[1].exp);

    // Randomized: opcodes biased towards the decoded set, all other fields random
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      if (n % 4 != 3) begin
        r[31:26] = 6'(ops[$urandom_range(0, 21)]);
      end
      if ((r[31:26] == 6'h00) && (n % 2 == 0)) begin
        r[5:0] = 6'(32'h10 + $urandom_range(0, 27));
      end
      apply(r);
      o = model(r);
      check("rand", got(), o);
      check_bit("inv_noreg", regw_enable || (regw_dst == 4'd0 && regw_src == 4'd0 && T == 5'd0));
      check_bit("inv_store", !memw_enable || (width != 3'd0 && !regw_enable));
      check_bit("inv_sext",  !sign_ext || (width != 3'd0 && !memw_enable));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
